// File: rtl/cpu_pkg.sv
// cpu_pkg: instruction field positions, opcodes, FSM states
// and the operation-select bundle shared by the control unit.
package cpu_pkg;

  localparam int IR_W   = 16;
  localparam int I_POS  = 15;
  localparam int OP_HI  = 14;
  localparam int OP_LO  = 12;
  localparam int SUB_HI = 11;
  localparam int SUB_LO = 8;

  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_LDA  = 3'b010;
  localparam logic [2:0] OP_STA  = 3'b011;
  localparam logic [2:0] OP_BUN  = 3'b100;
  localparam logic [2:0] OP_ISZ  = 3'b110;
  localparam logic [2:0] OP_RREF = 3'b111;

  localparam logic [3:0] SUB_CLA = 4'd0;
  localparam logic [3:0] SUB_CLE = 4'd1;
  localparam logic [3:0] SUB_CMA = 4'd2;
  localparam logic [3:0] SUB_LDI = 4'd3;
  localparam logic [3:0] SUB_CIR = 4'd4;
  localparam logic [3:0] SUB_CIL = 4'd5;
  localparam logic [3:0] SUB_INC = 4'd6;
  localparam logic [3:0] SUB_HLT = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DECODE,
    S_INDIRECT,
    S_EXECUTE,
    S_RETIRE,
    S_HALT
  } state_t;

  typedef struct packed {
    logic clr_ac;
    logic clr_e;
    logic comp_ac;
    logic load_ac;
    logic cir_r;
    logic cir_l;
    logic inc_ac;
    logic add;
    logic load;
    logic store;
    logic branch;
    logic isz;
  } sel_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational IR[15:8] decode into a one-hot
// operation select plus instruction class flags.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [IR_W-1:SUB_LO] ir,
  output sel_t                 sel,
  output logic                 is_memref,
  output logic                 is_ind,
  output logic                 is_halt,
  output logic                 is_illegal
);

  logic       ibit;
  logic [2:0] op;
  logic [3:0] sub;

  assign ibit = ir[I_POS];
  assign op   = ir[OP_HI:OP_LO];
  assign sub  = ir[SUB_HI:SUB_LO];

  always_comb begin
    sel        = '0;
    is_memref  = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD: begin sel.add    = 1'b1; is_memref = 1'b1; end
      OP_LDA: begin sel.load   = 1'b1; is_memref = 1'b1; end
      OP_STA: begin sel.store  = 1'b1; is_memref = 1'b1; end
      OP_BUN: begin sel.branch = 1'b1; is_memref = 1'b1; end
      OP_ISZ: begin sel.isz    = 1'b1; is_memref = 1'b1; end
      OP_RREF: begin
        if (ibit) begin
          is_illegal = 1'b1;
        end else begin
          case (sub)
            SUB_CLA: sel.clr_ac  = 1'b1;
            SUB_CLE: sel.clr_e   = 1'b1;
            SUB_CMA: sel.comp_ac = 1'b1;
            SUB_LDI: sel.load_ac = 1'b1;
            SUB_CIR: sel.cir_r   = 1'b1;
            SUB_CIL: sel.cir_l   = 1'b1;
            SUB_INC: sel.inc_ac  = 1'b1;
            SUB_HLT: is_halt     = 1'b1;
            default: is_illegal  = 1'b1;
          endcase
        end
      end
      default: is_illegal = 1'b1;
    endcase
  end

  assign is_ind = is_memref & ibit;

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore sequencing FSM driving datapath strobes,
// with handshake edge detect, execute timeout and retire count.
module control_unit
  import cpu_pkg::*;
#(
  parameter int FETCH_CYCLES = 4,
  parameter int EX_TIMEOUT   = 15
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [IR_W-1:0] i_ir,
  input  logic            i_ex_done,
  input  logic            i_w_mem_ref,
  output logic            o_clr_reg,
  output logic            o_fetch,
  output logic            o_execute,
  output logic            o_is_ind,
  output logic            o_is_dir,
  output logic            o_clr_ac,
  output logic            o_clr_e,
  output logic            o_comp_ac,
  output logic            o_load_ac,
  output logic            o_cir_r,
  output logic            o_cir_l,
  output logic            o_inc_ac,
  output logic            o_add,
  output logic            o_load,
  output logic            o_store,
  output logic            o_branch,
  output logic            o_isz,
  output logic            o_halted,
  output logic            o_error,
  output logic [15:0]     o_icount
);

  state_t               state_q, state_d;
  logic [3:0]           fcnt_q;
  logic [7:0]           tcnt_q;
  logic [IR_W-1:SUB_LO] ir_q, dec_ir;
  logic                 ex_q, wm_q;
  logic                 ex_rise, wm_rise;
  logic                 fdone, tout;
  logic                 err_set, retire;
  logic [15:0]          icount_q;
  sel_t                 sel, sel_q;
  logic                 is_memref, is_ind, is_halt, is_illegal;
  logic                 unused_ir;

  assign unused_ir = ^i_ir[SUB_LO-1:0];

  // Decode the live IR only in DECODE; afterwards use the latched copy.
  assign dec_ir = (state_q == S_DECODE) ? i_ir[IR_W-1:SUB_LO] : ir_q;

  instr_decoder u_dec (
    .ir         (dec_ir),
    .sel        (sel),
    .is_memref  (is_memref),
    .is_ind     (is_ind),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  assign ex_rise = i_ex_done & ~ex_q;
  assign wm_rise = i_w_mem_ref & ~wm_q;
  assign fdone   = fcnt_q == 4'(FETCH_CYCLES - 1);
  assign tout    = tcnt_q == 8'(EX_TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE:   if (i_start) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_FETCH;
      S_FETCH:  if (fdone) state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_illegal) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else if (is_ind) begin
          state_d = S_INDIRECT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_INDIRECT: begin
        if (wm_rise) begin
          state_d = S_EXECUTE;
        end else if (tout) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_EXECUTE: begin
        if (ex_rise) begin
          retire  = 1'b1;
          state_d = S_RETIRE;
        end else if (tout) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end
      end
      S_RETIRE: state_d = S_FETCH;
      S_HALT:   if (i_start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      tcnt_q    <= '0;
      ir_q      <= '0;
      ex_q      <= 1'b0;
      wm_q      <= 1'b0;
      icount_q  <= '0;
      o_error   <= 1'b0;
      o_clr_reg <= 1'b0;
      o_fetch   <= 1'b0;
      o_execute <= 1'b0;
      o_is_ind  <= 1'b0;
      o_is_dir  <= 1'b0;
      o_halted  <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= i_ex_done;
      wm_q    <= i_w_mem_ref;
      fcnt_q  <= (state_q == S_FETCH && !fdone) ? fcnt_q + 4'd1 : '0;
      // Restarts on every state change, so entry always begins at zero.
      tcnt_q  <= (state_d == state_q &&
                  (state_q == S_INDIRECT || state_q == S_EXECUTE))
                 ? tcnt_q + 8'd1 : '0;
      if (state_q == S_DECODE) ir_q <= i_ir[IR_W-1:SUB_LO];
      if (retire) icount_q <= icount_q + 16'd1;
      if (err_set) o_error <= 1'b1;
      o_clr_reg <= state_d == S_CLEAR;
      o_fetch   <= state_d == S_FETCH;
      o_execute <= state_d == S_EXECUTE;
      o_is_ind  <= state_d == S_INDIRECT;
      o_is_dir  <= (state_d == S_EXECUTE) && is_memref;
      o_halted  <= state_d == S_HALT;
      sel_q     <= (state_d == S_INDIRECT || state_d == S_EXECUTE)
                   ? sel : '0;
    end
  end

  assign o_icount  = icount_q;
  assign o_clr_ac  = sel_q.clr_ac;
  assign o_clr_e   = sel_q.clr_e;
  assign o_comp_ac = sel_q.comp_ac;
  assign o_load_ac = sel_q.load_ac;
  assign o_cir_r   = sel_q.cir_r;
  assign o_cir_l   = sel_q.cir_l;
  assign o_inc_ac  = sel_q.inc_ac;
  assign o_add     = sel_q.add;
  assign o_load    = sel_q.load;
  assign o_store   = sel_q.store;
  assign o_branch  = sel_q.branch;
  assign o_isz     = sel_q.isz;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven, hand-written corner and random
// instruction streams checked cycle by cycle against a decode model.
module tb_control_unit;

  localparam int FC = 4;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_ex_done, i_w_mem_ref;
  logic [15:0] i_ir;
  logic        o_clr_reg, o_fetch, o_execute, o_is_ind, o_is_dir;
  logic        o_clr_ac, o_clr_e, o_comp_ac, o_load_ac;
  logic        o_cir_r, o_cir_l, o_inc_ac;
  logic        o_add, o_load, o_store, o_branch, o_isz;
  logic        o_halted, o_error;
  logic [15:0] o_icount;

  int          total = 0;
  int          passed = 0;
  logic [15:0] mcnt;
  logic        merr;

  always #5 clk = ~clk;

  control_unit #(.FETCH_CYCLES(FC), .EX_TIMEOUT(TO)) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_ir(i_ir),
    .i_ex_done(i_ex_done), .i_w_mem_ref(i_w_mem_ref),
    .o_clr_reg(o_clr_reg), .o_fetch(o_fetch), .o_execute(o_execute),
    .o_is_ind(o_is_ind), .o_is_dir(o_is_dir),
    .o_clr_ac(o_clr_ac), .o_clr_e(o_clr_e), .o_comp_ac(o_comp_ac),
    .o_load_ac(o_load_ac), .o_cir_r(o_cir_r), .o_cir_l(o_cir_l),
    .o_inc_ac(o_inc_ac), .o_add(o_add), .o_load(o_load),
    .o_store(o_store), .o_branch(o_branch), .o_isz(o_isz),
    .o_halted(o_halted), .o_error(o_error), .o_icount(o_icount)
  );

  // Select mask order: clr_ac clr_e comp_ac load_ac cir_r cir_l inc_ac
  //                    add load store branch isz
  typedef struct packed {
    logic [11:0] m;
    logic        mem;
    logic        ind;
    logic        hlt;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [11:0] m;
    logic        mem;
    logic        ind;
    logic [3:0]  idly;
    logic [3:0]  edly;
  } vec_t;

  vec_t tbl [13];

  function automatic dec_t ref_dec(input logic [15:0] ir);
    dec_t d;
    int   op, sub;
    op  = int'(ir[14:12]);
    sub = int'(ir[11:8]);
    d   = '0;
    if (op == 7 && !ir[15]) begin
      if (sub == 7)     d.hlt = 1'b1;
      else if (sub < 7) d.m   = 12'h800 >> sub;
      else              d.ill = 1'b1;
    end else if (op == 1 || op == 2 || op == 3 || op == 4 || op == 6) begin
      d.mem = 1'b1;
      d.ind = ir[15];
      d.m   = (op == 6) ? 12'h001 : (12'h020 >> op);
    end else begin
      d.ill = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [18:0] obs();
    return {o_clr_reg, o_fetch, o_execute, o_is_ind, o_is_dir,
            o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l,
            o_inc_ac, o_add, o_load, o_store, o_branch, o_isz,
            o_halted, o_error};
  endfunction

  function automatic logic [18:0] expo(
    input logic clr, fet, exe, ind, dir,
    input logic [11:0] m, input logic hlt);
    return {clr, fet, exe, ind, dir, m, hlt, merr};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic look(input string nm, input logic [18:0] e);
    chk(nm, 32'(obs()), 32'(e));
    chk({nm, " cnt"}, 32'(o_icount), 32'(mcnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_clear();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    look("clear", expo(1, 0, 0, 0, 0, 12'h0, 0));
    step();
  endtask

  task automatic run_instr(input string nm, input logic [15:0] ir,
                           input dec_t d, input int idly, input int edly);
    i_ir = ir;
    for (int k = 0; k < FC; k++) begin
      look({nm, " fetch"}, expo(0, 1, 0, 0, 0, 12'h0, 0));
      step();
    end
    look({nm, " decode"}, expo(0, 0, 0, 0, 0, 12'h0, 0));
    step();
    i_ir = 16'($urandom);
    if (d.hlt || d.ill) begin
      if (d.ill) merr = 1'b1;
      look({nm, " halt"}, expo(0, 0, 0, 0, 0, 12'h0, 1));
      return;
    end
    if (d.ind) begin
      for (int k = 0; k <= idly; k++) begin
        look({nm, " ind"}, expo(0, 0, 0, 1, 0, d.m, 0));
        if (k == idly) i_w_mem_ref = 1'b1;
        step();
      end
      i_w_mem_ref = 1'b0;
    end
    for (int k = 0; k <= edly; k++) begin
      look({nm, " exe"}, expo(0, 0, 1, 0, d.mem, d.m, 0));
      if (k == edly) i_ex_done = 1'b1;
      step();
    end
    i_ex_done = 1'b0;
    mcnt = mcnt + 16'd1;
    look({nm, " retire"}, expo(0, 0, 0, 0, 0, 12'h0, 0));
    step();
  endtask

  initial begin
    dec_t d;
    logic [15:0] rir;

    tbl[0]  = '{16'h7600, 12'h020, 1'b0, 1'b0, 4'd0,  4'd1};
    tbl[1]  = '{16'h9123, 12'h010, 1'b1, 1'b1, 4'd2,  4'd3};
    tbl[2]  = '{16'h2ABC, 12'h008, 1'b1, 1'b0, 4'd0,  4'd0};
    tbl[3]  = '{16'h3010, 12'h004, 1'b1, 1'b0, 4'd0,  4'd2};
    tbl[4]  = '{16'h4000, 12'h002, 1'b1, 1'b0, 4'd0,  4'd0};
    tbl[5]  = '{16'hE005, 12'h001, 1'b1, 1'b1, 4'd14, 4'd14};
    tbl[6]  = '{16'h7000, 12'h800, 1'b0, 1'b0, 4'd0,  4'd0};
    tbl[7]  = '{16'h71FF, 12'h400, 1'b0, 1'b0, 4'd0,  4'd4};
    tbl[8]  = '{16'h7200, 12'h200, 1'b0, 1'b0, 4'd0,  4'd0};
    tbl[9]  = '{16'h7300, 12'h100, 1'b0, 1'b0, 4'd0,  4'd0};
    tbl[10] = '{16'h7400, 12'h080, 1'b0, 1'b0, 4'd0,  4'd0};
    tbl[11] = '{16'h7500, 12'h040, 1'b0, 1'b0, 4'd0,  4'd0};
    tbl[12] = '{16'hB777, 12'h004, 1'b1, 1'b1, 4'd5,  4'd0};

    i_rst = 1'b1; i_start = 1'b0; i_ex_done = 1'b0;
    i_w_mem_ref = 1'b0; i_ir = 16'h0;
    mcnt = 16'h0; merr = 1'b0;
    step(); step();
    look("reset", 19'h0);
    i_rst = 1'b0;
    step();
    look("idle", 19'h0);
    start_clear();

    foreach (tbl[i]) begin
      d = '{tbl[i].m, tbl[i].mem, tbl[i].ind, 1'b0, 1'b0};
      run_instr($sformatf("tbl%0d", i), tbl[i].ir, d,
                int'(tbl[i].idly), int'(tbl[i].edly));
    end

    // Reset while INC is executing
    i_ir = 16'h7600;
    for (int k = 0; k <= FC; k++) step();
    look("pre-rst exe", expo(0, 0, 1, 0, 0, 12'h020, 0));
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    mcnt = 16'h0;
    look("rst mid-exe", 19'h0);
    step();
    look("rst idle", 19'h0);

    // Stale-high ex_done never retires; timeout halts with error
    start_clear();
    i_ex_done = 1'b1;
    i_ir = 16'h3010;
    for (int k = 0; k <= FC; k++) step();
    for (int k = 0; k < TO; k++) begin
      look("stale exe", expo(0, 0, 1, 0, 1, 12'h004, 0));
      step();
    end
    merr = 1'b1;
    look("timeout halt", expo(0, 0, 0, 0, 0, 12'h0, 1));
    i_ex_done = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    look("err restart", expo(0, 1, 0, 0, 0, 12'h0, 0));

    // HLT keeps the count and restarts without CLEAR
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    mcnt = 16'h0; merr = 1'b0;
    start_clear();
    run_instr("lda", 16'h2005, ref_dec(16'h2005), 0, 1);
    run_instr("hlt", 16'h7700, '{12'h0, 1'b0, 1'b0, 1'b1, 1'b0}, 0, 0);
    step();
    look("hlt hold", expo(0, 0, 0, 0, 0, 12'h0, 1));
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    look("hlt no clear", expo(0, 1, 0, 0, 0, 12'h0, 0));

    // Illegal opcode, then a wrap of a preset count
    run_instr("ill", 16'h5000, '{12'h0, 1'b0, 1'b0, 1'b0, 1'b1}, 0, 0);
    force dut.icount_q = 16'hFFFF;
    step();
    release dut.icount_q;
    step();
    mcnt = 16'hFFFF;
    look("ill hold", expo(0, 0, 0, 0, 0, 12'h0, 1));
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    run_instr("wrap", 16'h7100, ref_dec(16'h7100), 0, 0);
    chk("wrap zero", 32'(o_icount), 32'h0);

    // Random legal stream
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    mcnt = 16'h0; merr = 1'b0;
    start_clear();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        rir = 16'($urandom);
        case ($urandom_range(0, 4))
          0: rir[14:12] = 3'd1;
          1: rir[14:12] = 3'd2;
          2: rir[14:12] = 3'd3;
          3: rir[14:12] = 3'd4;
          default: rir[14:12] = 3'd6;
        endcase
      end else begin
        rir = {4'h7, 4'($urandom_range(0, 6)), 8'($urandom)};
      end
      run_instr($sformatf("rnd%0d", n), rir, ref_dec(rir),
                $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencing FSM sitting directly upstream of the CPU datapath. Decodes the instruction register the datapath returns and drives every datapath control strobe: reset, fetch, indirect-address resolve, direct execute and the per-instruction operation selects. It advances on the datapath's completion handshakes, counts retired instructions and halts on HLT or on an execute timeout.

## Interface
Parameters:
- FETCH_CYCLES, 4: cycles `o_fetch` is held per instruction fetch (2..15).
- EX_TIMEOUT, 15: maximum EXECUTE/INDIRECT cycles without a handshake before error (1..255).

Ports:
- `clk` in 1: sole clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: level; leaves IDLE/HALT and begins fetching.
- `i_ir` in 16: instruction register from datapath.
- `i_ex_done` in 1: datapath execute-complete.
- `i_w_mem_ref` in 1: datapath indirect-address-loaded.
- `o_clr_reg` out 1: datapath register clear pulse.
- `o_fetch` out 1: fetch request.
- `o_execute` out 1: execute phase.
- `o_is_ind` out 1: indirect resolve phase.
- `o_is_dir` out 1: direct memory-reference execute.
- `o_clr_ac`, `o_clr_e`, `o_comp_ac`, `o_load_ac`, `o_cir_r`, `o_cir_l`, `o_inc_ac` out 1 each: register-reference selects.
- `o_add`, `o_load`, `o_store`, `o_branch`, `o_isz` out 1 each: memory-reference selects.
- `o_halted` out 1: in HALT.
- `o_error` out 1: sticky; illegal opcode or timeout.
- `o_icount` out 16: retired-instruction count.

## Operation
- Decode: I = IR[15], op = IR[14:12]. Memory-reference: 001 ADD, 010 LDA, 011 STA, 100 BUN, 110 ISZ. op 111 with I=0 is register-reference, sub-op IR[11:8]: 0 CLA, 1 CLE, 2 CMA, 3 LDI, 4 CIR, 5 CIL, 6 INC, 7 HLT. Anything else is illegal.
- States: IDLE, CLEAR, FETCH, DECODE, INDIRECT, EXECUTE, RETIRE, HALT.
- IDLE: all outputs low. `i_start` → CLEAR.
- CLEAR: `o_clr_reg`=1 for exactly one cycle → FETCH.
- FETCH: `o_fetch`=1 for FETCH_CYCLES cycles, counted by the fetch counter → DECODE.
- DECODE: one cycle with all strobes low. `i_ir` latched into the internal IR copy and decoded. Transitions:
  - HLT → HALT.
  - Illegal → set `o_error`, then HALT.
  - Memory-reference with I=1 → INDIRECT.
  - Otherwise → EXECUTE.
- INDIRECT: `o_is_ind`=1 with the operation select held. Rising edge of `i_w_mem_ref` → EXECUTE.
- EXECUTE:
  - `o_execute`=1 plus exactly one operation select. `o_is_dir`=1 for memory-reference only.
  - Ends on a rising edge of `i_ex_done` (current high, previous-cycle low; edge register reset 0) → RETIRE.
  - A stale high `i_ex_done` never ends a new instruction.
- RETIRE: one cycle, all strobes low. `o_icount`+1, wrapping 0xFFFF→0 → FETCH.
- Timeout: a cycle counter resets on entry to INDIRECT/EXECUTE. Reaching EX_TIMEOUT without the handshake → `o_error`=1, then HALT.
- HALT: `o_halted`=1, strobes low. `i_start` → FETCH (no CLEAR); `o_error` is retained.
- `i_rst` dominates every state and input.

## Timing
- All outputs are registered (Moore), changing only on `clk` rising edge.
- Reset values: state IDLE; every output 0; `o_icount` 0; counters 0.
- Register-reference instruction from `i_start` at edge 0:
  - CLEAR at cycle 1.
  - FETCH at cycles 2..1+FETCH_CYCLES.
  - DECODE at cycle 2+FETCH_CYCLES.
  - EXECUTE from the next cycle.
- Retire-to-next-fetch gap is 1 cycle (RETIRE).
- Handshake edges are sampled in the cycle they are seen; the state changes on the following edge.
- Simultaneous timeout and handshake in the same cycle: the handshake wins.
- `i_start` is ignored outside IDLE/HALT.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode and sub-op localparams;
  - the state enum;
  - the field positions for I/op/sub-op.
- Sub-module `instr_decoder`: combinational IR → one-hot select vector plus is_memref / is_ind / is_halt / is_illegal. The FSM registers its outputs.

## Test plan
- Reset mid-EXECUTE (INC in progress) → next cycle all outputs 0, state IDLE, `o_icount`=0.
- IR=0x7600 (INC), `i_ex_done` pulsed on the 2nd EXECUTE cycle → `o_inc_ac` high exactly while `o_execute`=1, `o_icount`=1, next FETCH lasts 4 cycles.
- IR=0x9123 (I=1, ADD) → INDIRECT with `o_is_ind`=1 until the `i_w_mem_ref` edge, then `o_execute`, `o_is_dir`, `o_add` together until the `i_ex_done` edge.
- `i_ex_done` held high from before EXECUTE and never toggled, IR=0x3010 (STA) → no retire; after 15 EXECUTE cycles `o_error`=1, `o_halted`=1.
- IR=0x7700 (HLT) → HALT with `o_icount` unchanged. `i_start` → FETCH without `o_clr_reg`.
- IR=0x5000 (illegal op 101) → `o_error`=1, HALT, no execute strobe ever asserted. `o_icount` preset to 0xFFFF wraps to 0 on the next retire.
